// File: rtl/nes_pkg.sv
// Shared constants, palette reset values and fetch-state encoding for the NES tile painter.
package nes_pkg;

  localparam logic [9:0] H_TOTAL = 10'd800;
  localparam logic [9:0] V_TOTAL = 10'd525;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] REGION  = 10'd256;

  // Colour shown outside the visible area.
  localparam logic [5:0] BLANK_COLOR = 6'h0F;

  localparam logic [5:0] PAL_RST0 = 6'h0F;
  localparam logic [5:0] PAL_RST1 = 6'h00;
  localparam logic [5:0] PAL_RST2 = 6'h10;
  localparam logic [5:0] PAL_RST3 = 6'h30;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI
  } fetch_state_t;

  function automatic logic [5:0] pal_reset(input logic [1:0] idx);
    case (idx)
      2'd0:    return PAL_RST0;
      2'd1:    return PAL_RST1;
      2'd2:    return PAL_RST2;
      default: return PAL_RST3;
    endcase
  endfunction

  // Pattern ROM address: {tile, plane, row}.
  function automatic logic [11:0] pat_addr(input logic [7:0] tile, input logic plane,
                                           input logic [2:0] row);
    return {tile, plane, row};
  endfunction

endpackage

// File: rtl/nes_pat_fetch.sv
// Pattern fetcher: reads both bit planes of the next tile during phases 13..15
// and swaps them into the current plane registers at the edge ending phase 15.
module nes_pat_fetch
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pxl_x,
  input  logic [9:0]  pxl_y,
  input  logic [7:0]  rom_data,
  output logic [11:0] rom_addr,
  output logic [7:0]  cur0,
  output logic [7:0]  cur1
);

  localparam logic [9:0] LAST_TILE_X = 10'd237;
  localparam logic [9:0] LINE_X      = H_TOTAL - 10'd3;

  fetch_state_t state;
  logic [7:0]   pend0;
  logic         tgt_ok;
  logic [9:0]   tgt_y;
  logic [3:0]   tgt_col;

  // Decide whether this cycle starts a fetch and which tile it targets.
  always_comb begin
    tgt_ok  = 1'b0;
    tgt_y   = pxl_y;
    tgt_col = '0;
    if (pxl_x[3:0] == 4'd13) begin
      if ((pxl_x <= LAST_TILE_X) && (pxl_y < REGION)) begin
        tgt_ok  = 1'b1;
        tgt_col = pxl_x[7:4] + 4'd1;
      end else if (pxl_x == LINE_X) begin
        tgt_y = (pxl_y == V_TOTAL - 10'd1) ? '0 : pxl_y + 10'd1;
        if (tgt_y < REGION) tgt_ok = 1'b1;
      end
    end
  end

  // Fetch FSM: plane 0 then plane 1, then commit both planes together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      pend0    <= '0;
      cur0     <= '0;
      cur1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tgt_ok) begin
            rom_addr <= pat_addr({tgt_y[7:4], tgt_col}, 1'b0, tgt_y[3:1]);
            state    <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          pend0       <= rom_data;
          rom_addr[3] <= 1'b1;
          state       <= FETCH_HI;
        end
        FETCH_HI: begin
          cur0  <= pend0;
          cur1  <= rom_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nes_tile_painter.sv
// NES-style tile painter: 16x16 tiles in the top-left 256x256 pixels, each
// pattern pixel doubled, mapped through a 4-entry writable palette.
module nes_tile_painter
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pxl_x,
  input  logic [9:0]  pxl_y,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        pal_we,
  input  logic [1:0]  pal_wa,
  input  logic [5:0]  pal_wd,
  output logic [5:0]  color_idx,
  output logic        vis_o
);

  logic [7:0] cur0;
  logic [7:0] cur1;
  logic [5:0] pal [4];
  logic       vis;
  logic       in_region;
  logic [2:0] bit_sel;
  logic [1:0] pix;
  logic [5:0] color_next;

  nes_pat_fetch u_fetch (
    .clk      (clk),
    .rst      (rst),
    .pxl_x    (pxl_x),
    .pxl_y    (pxl_y),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .cur0     (cur0),
    .cur1     (cur1)
  );

  // Select the pixel value and palette colour for the current coordinate.
  always_comb begin
    vis        = (pxl_x < H_VIS) && (pxl_y < V_VIS);
    in_region  = (pxl_x < REGION) && (pxl_y < REGION);
    bit_sel    = 3'd7 - pxl_x[3:1];
    pix        = {cur1[bit_sel], cur0[bit_sel]};
    color_next = pal[0];
    if (!vis) begin
      color_next = BLANK_COLOR;
    end else if (in_region) begin
      color_next = pal[pix];
    end
  end

  // Register the output colour and handle palette writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) pal[i] <= pal_reset(i[1:0]);
      color_idx <= BLANK_COLOR;
      vis_o     <= 1'b0;
    end else begin
      if (pal_we) pal[pal_wa] <= pal_wd;
      color_idx <= color_next;
      vis_o     <= vis;
    end
  end

endmodule
